// File: rtl/mul_mdc_join_mac.sv
`default_nettype none
// ============================================================================
// Module   : mul_mdc_join_mac
// Purpose  : Joins the a/b/c load streams and computes d = a*b + c over a
//            two-stage valid/ready pipeline, with job length tracking.
// Revision : 1.0 - initial release
// ============================================================================
module mul_mdc_join_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic [DATA_WIDTH-1:0] c_data_i,
    input  logic                  a_valid_i,
    input  logic                  b_valid_i,
    input  logic                  c_valid_i,
    output logic                  a_ready_o,
    output logic                  b_ready_o,
    output logic                  c_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  d_valid_o,
    input  logic                  d_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  out_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_in_cnt;
    logic [CNT_WIDTH-1:0]  r_out_cnt;
    logic [CNT_WIDTH-1:0]  w_in_cnt_inc;
    logic [CNT_WIDTH-1:0]  w_out_cnt_inc;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_p;
    logic [DATA_WIDTH-1:0] r_s1_c;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_d;

    logic                  w_s1_can_accept;
    logic                  w_s2_can_accept;
    logic                  w_fire;
    logic                  w_d_xfer;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_sum;

    // Backpressure is derived from stage occupancy and d_ready_i only, so
    // d_valid_o (a register) never depends combinationally on d_ready_i.
    assign w_s2_can_accept = !r_s2_valid || d_ready_i;
    assign w_s1_can_accept = !r_s1_valid || w_s2_can_accept;
    assign w_fire          = (r_state == ST_RUN) && a_valid_i && b_valid_i && c_valid_i
                             && w_s1_can_accept && (r_in_cnt < r_len);
    assign w_d_xfer        = r_s2_valid && d_ready_i;
    assign w_busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_in_cnt_inc    = r_in_cnt + c_cnt_one;
    assign w_out_cnt_inc   = r_out_cnt + c_cnt_one;
    assign w_prod          = a_data_i * b_data_i;
    assign w_sum           = r_s1_p + r_s1_c;

    assign a_ready_o = w_fire;
    assign b_ready_o = w_fire;
    assign c_ready_o = w_fire;
    assign d_valid_o = r_s2_valid;
    assign d_data_o  = r_s2_d;
    assign busy_o    = w_busy;
    assign done_o    = (r_state == ST_DONE);
    assign out_cnt_o = r_out_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_fire && (w_in_cnt_inc == r_len)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_d_xfer && (w_out_cnt_inc == r_len)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (clear_i) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && start_i) begin
                r_len     <= len_i;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_fire) begin
                    r_in_cnt <= w_in_cnt_inc;
                end
                if (w_d_xfer && w_busy) begin
                    r_out_cnt <= w_out_cnt_inc;
                end
            end
        end
    end

    // Each stage loads whenever its successor is empty or draining this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_c     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_d     <= '0;
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_can_accept) begin
                r_s1_valid <= w_fire;
            end
            if (w_fire) begin
                r_s1_p <= w_prod;
                r_s1_c <= c_data_i;
            end
            if (w_s2_can_accept) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_d <= w_sum;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_mdc_join_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_mdc_join_mac
// Purpose  : Randomized self-checking bench for mul_mdc_join_mac against a
//            job-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_mdc_join_mac;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic [DW-1:0] a_data_i, b_data_i, c_data_i;
    logic          a_valid_i, b_valid_i, c_valid_i;
    logic          a_ready_o, b_ready_o, c_ready_o;
    logic [DW-1:0] d_data_o;
    logic          d_valid_o;
    logic          d_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] out_cnt_o;

    mul_mdc_join_mac #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .a_data_i  (a_data_i),
        .b_data_i  (b_data_i),
        .c_data_i  (c_data_i),
        .a_valid_i (a_valid_i),
        .b_valid_i (b_valid_i),
        .c_valid_i (c_valid_i),
        .a_ready_o (a_ready_o),
        .b_ready_o (b_ready_o),
        .c_ready_o (c_ready_o),
        .d_data_o  (d_data_o),
        .d_valid_o (d_valid_o),
        .d_ready_i (d_ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .out_cnt_o (out_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Job operands; element i uses entry i mod 64.
    logic [DW-1:0] arr_a [0:63];
    logic [DW-1:0] arr_b [0:63];
    logic [DW-1:0] arr_c [0:63];

    // Reference model state (job level).
    bit  m_busy = 0;
    bit  m_done = 0;
    int  m_len = 0;
    int  m_acc = 0;
    int  m_out = 0;
    int  acc_time [0:65535];
    int  fire_cyc0 = 0;
    int  done_cnt = 0;
    int  done_base = 0;
    logic [DW-1:0] got_q [$];
    int            got_t [$];

    // Stimulus knobs.
    int pv = 100;
    int pr = 100;
    bit c_hold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_d(input int i);
        logic [DW-1:0] p;
        p = arr_a[i & 63] * arr_b[i & 63];
        return p + arr_c[i & 63];
    endfunction

    // Compare process: every cycle, the DUT outputs against the model.
    always @(negedge clk) begin : compare
        bit all_v, exp_rdy, exp_dv, acc, xfer, nd;
        cyc++;
        done_cnt += int'(done_o);
        if (!rst_ni) begin
            chk("reset_outputs",
                {a_ready_o, b_ready_o, c_ready_o, d_valid_o, busy_o, done_o, out_cnt_o, d_data_o}, 64'd0);
            m_busy = 0; m_done = 0; m_acc = 0; m_out = 0; m_len = 0;
        end else begin
            all_v   = a_valid_i && b_valid_i && c_valid_i;
            exp_rdy = m_busy && (m_acc < m_len) && all_v && (((m_acc - m_out) < 2) || d_ready_i);
            exp_dv  = (m_out < m_acc) && (cyc >= acc_time[m_out] + 2);
            chk("readies", {a_ready_o, b_ready_o, c_ready_o}, {3{exp_rdy}});
            chk("d_valid", d_valid_o, exp_dv);
            if (exp_dv) chk("d_data", d_data_o, model_d(m_out));
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            chk("out_cnt", out_cnt_o, m_out);

            acc  = a_ready_o && all_v;
            xfer = d_valid_o && d_ready_i;
            if (clear_i) begin
                m_busy = 0; m_done = 0; m_acc = 0; m_out = 0;
            end else begin
                nd = 0;
                if (m_busy) begin
                    if (acc) begin
                        if (m_acc == 0) fire_cyc0 = cyc;
                        acc_time[m_acc] = cyc;
                        m_acc++;
                    end
                    if (xfer) begin
                        got_q.push_back(d_data_o);
                        got_t.push_back(cyc);
                        m_out++;
                        if (m_out == m_len) begin
                            m_busy = 0;
                            nd = 1;
                        end
                    end
                end else if (!m_done && start_i) begin
                    m_acc = 0;
                    m_out = 0;
                    if (len_i != '0) begin
                        m_busy = 1;
                        m_len  = int'(len_i);
                    end else begin
                        nd = 1;
                    end
                end
                m_done = nd;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        clear_i   = 1'b0;
        a_valid_i = ($urandom_range(99) < pv);
        b_valid_i = ($urandom_range(99) < pv);
        c_valid_i = ($urandom_range(99) < pv) && !c_hold;
        if (m_busy && (m_acc < m_len)) begin
            a_data_i = arr_a[m_acc & 63];
            b_data_i = arr_b[m_acc & 63];
            c_data_i = arr_c[m_acc & 63];
        end else begin
            a_data_i = $urandom;
            b_data_i = $urandom;
            c_data_i = $urandom;
        end
        d_ready_i = ($urandom_range(99) < pr);
    endtask

    task automatic rand_arrays();
        for (int i = 0; i < 64; i++) begin
            arr_a[i] = $urandom;
            arr_b[i] = $urandom;
            arr_c[i] = $urandom;
        end
    endtask

    task automatic start_job(input int len);
        step();
        start_i   = 1'b1;
        len_i     = len[CW-1:0];
        done_base = done_cnt;
        got_q.delete();
        got_t.delete();
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            step();
            if (done_cnt != done_base) break;
        end
        chk(name, done_cnt - done_base, 1);
    endtask

    initial begin : stim
        int dc;
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
        a_data_i = '0; b_data_i = '0; c_data_i = '0;
        a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0; d_ready_i = 1'b0;
        rand_arrays();
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        // Directed job: 4 elements, full throughput.
        for (int i = 0; i < 4; i++) begin
            arr_a[i] = DW'(i + 1); arr_b[i] = 32'd10; arr_c[i] = 32'd5;
        end
        pv = 100; pr = 100;
        start_job(4);
        wait_done(30, "t1_done");
        chk("t1_count", got_q.size(), 4);
        chk("t1_d0", got_q[0], 32'd15);
        chk("t1_d1", got_q[1], 32'd25);
        chk("t1_d2", got_q[2], 32'd35);
        chk("t1_d3", got_q[3], 32'd45);
        chk("t1_latency", got_t[0] - fire_cyc0, 2);
        chk("t1_throughput", got_t[3] - got_t[0], 3);
        chk("t1_out_cnt", out_cnt_o, 4);

        // Wrapping arithmetic.
        arr_a[0] = 32'hFFFF_FFFF; arr_b[0] = 32'd2; arr_c[0] = 32'd3;
        start_job(1);
        wait_done(20, "t2_done");
        chk("t2_wrap", got_q[0], 32'h0000_0001);

        // c stream withheld: no partial join.
        arr_a[0] = 32'd7; arr_b[0] = 32'd6; arr_c[0] = 32'd1;
        c_hold = 1;
        start_job(1);
        repeat (5) step();
        chk("t3_no_xfer", m_acc, 0);
        c_hold = 0;
        wait_done(20, "t3_done");
        chk("t3_value", got_q[0], 32'd43);

        // Random backpressure, with an ignored start mid-job.
        rand_arrays();
        pv = 100; pr = 50;
        start_job(8);
        step(); step();
        start_i = 1'b1; len_i = 16'd3;
        wait_done(300, "t4_done");
        chk("t4_count", got_q.size(), 8);
        chk("t4_out_cnt", out_cnt_o, 8);

        // Zero-length job.
        start_job(0);
        wait_done(3, "t5_len0_done");
        chk("t5_no_output", got_q.size(), 0);
        step();

        // Soft clear with elements in flight.
        rand_arrays();
        pv = 100; pr = 0;
        start_job(6);
        for (int k = 0; k < 10 && m_acc < 2; k++) step();
        chk("t6_inflight", m_acc, 2);
        step();
        clear_i = 1'b1;
        dc = done_cnt;
        step();
        repeat (3) step();
        chk("t6_no_done", done_cnt - dc, 0);
        chk("t6_idle", {busy_o, d_valid_o}, 2'b00);
        pr = 100;
        start_job(2);
        wait_done(20, "t6_after_clear_done");
        chk("t6_after_clear_count", got_q.size(), 2);

        // Asynchronous reset mid-job.
        pr = 50;
        start_job(10);
        repeat (4) step();
        rst_ni = 1'b0;
        #2;
        chk("t7_async_rst", {busy_o, d_valid_o, a_ready_o, out_cnt_o}, 19'd0);
        step(); step();
        rst_ni = 1'b1;
        start_job(3);
        wait_done(60, "t7_after_rst_done");

        // Random jobs.
        for (int j = 0; j < 6; j++) begin
            int len;
            rand_arrays();
            pv  = $urandom_range(70, 100);
            pr  = $urandom_range(20, 100);
            len = $urandom_range(1, 20);
            start_job(len);
            wait_done(len * 40 + 50, "rand_done");
            chk("rand_count", got_q.size(), len);
        end

        // Maximum length, no counter wrap.
        rand_arrays();
        pv = 100; pr = 100;
        start_job(65535);
        wait_done(65600, "max_len_done");
        chk("max_len_out_cnt", out_cnt_o, 16'hFFFF);
        chk("max_len_count", got_q.size(), 65535);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mul_mdc_join_mac.md
Name: mul_mdc_join_mac

Overview:
- Compute stage of the mul_mdc accelerator. Sits directly downstream of the streamer's three load streams (a, b, c) and upstream of the streamer's store stream (d).
- Joins one element from each input stream and computes d = a*b + c, modulo 2^DATA_WIDTH.
- Pipelined over two registered stages, with full valid/ready backpressure.
- Counts a programmed job length and reports busy/done to the controller.

Parameters:
- DATA_WIDTH, 32, width of a, b, c and d data.
- CNT_WIDTH, 16, width of the job length and element counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous soft clear from the controller.
- start_i  in  1  one-cycle job start pulse.
- len_i  in  CNT_WIDTH  number of elements in the job; sampled on start_i.
- a_data_i, b_data_i, c_data_i  in  DATA_WIDTH  input operands.
- a_valid_i, b_valid_i, c_valid_i  in  1  input valids.
- a_ready_o, b_ready_o, c_ready_o  out  1  input readies.
- d_data_o  out  DATA_WIDTH  result.
- d_valid_o  out  1  result valid.
- d_ready_i  in  1  result ready.
- busy_o  out  1  high while a job is active.
- done_o  out  1  one-cycle pulse at job completion.
- out_cnt_o  out  CNT_WIDTH  number of results handed off in the current job.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, pipeline empty, counters 0.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both high.
  - Once d_valid_o is asserted, d_valid_o and d_data_o stay stable until the transfer.
  - d_valid_o never depends combinationally on d_ready_i.
- Join:
  - fire = RUN & a_valid_i & b_valid_i & c_valid_i & s1_can_accept & (in_cnt < len_q).
  - a_ready_o = b_ready_o = c_ready_o = fire. All three streams are consumed on the same cycle or none is.
  - A partial set of valids never raises any ready.
- Pipeline:
  - S1 registers the low DATA_WIDTH bits of a*b, plus c.
  - S2 registers p + c, truncated to DATA_WIDTH. S2 drives d_data_o, and d_valid_o is the S2 valid.
  - A stage advances when the next stage is empty or is transferring on the same cycle.
  - s1_can_accept = !s1_valid | s2_can_accept.
  - s2_can_accept = !s2_valid | d_ready_i.
  - Latency from fire to d_valid_o is 2 cycles. Throughput is 1 element/cycle while d_ready_i is held high. No element is lost or duplicated under any stall pattern.
- Arithmetic: a*b is truncated to DATA_WIDTH, then added to c and truncated again. The result is sign-agnostic.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: busy_o=0.
    - start_i with len_i>0: latch len_q, clear counters, go to RUN.
    - start_i with len_i=0: go directly to DONE.
  - RUN: busy_o=1. in_cnt increments on each fire. When in_cnt reaches len_q, go to DRAIN; input readies stay 0 from then on.
  - DRAIN: busy_o=1. out_cnt_o increments on each d transfer. When out_cnt_o reaches len_q, go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o=0. Next state is IDLE. out_cnt_o holds its value until the next start.
- Boundary conditions:
  - start_i while busy is ignored.
  - clear_i has priority over every other event, including start_i and transfers on the same cycle. It empties S1 and S2, zeroes counters and d_valid_o, returns the FSM to IDLE, and produces no done_o.
  - Asynchronous reset mid-job has the same effect as clear_i, applied immediately.
  - Extra input valids beyond len_q are never accepted.
  - len_i = 2^CNT_WIDTH-1 completes normally without counter wrap.

Test Plan:
- len=4; a={1,2,3,4}, b={10,10,10,10}, c={5,5,5,5}; d_ready_i=1 -> d={15,25,35,45}. First d_valid_o 2 cycles after the first fire, 1 element/cycle. done_o pulses once; out_cnt_o=4.
- a=0xFFFFFFFF, b=2, c=3, len=1 -> d=0x00000001, i.e. (0x1FFFFFFFE mod 2^32)+3, wrapped.
- c_valid_i held low for 5 cycles while a and b are valid -> all readies stay 0 and no transfer occurs. When c_valid_i rises, one joint transfer happens.
- len=8, d_ready_i toggled with a random 50% pattern -> all 8 results in order with d_data_o stable while stalled. Input readies drop when S1 and S2 are full.
- start with len=0 -> done_o pulses one cycle after start, no d_valid_o, busy_o stays 0.
- clear_i asserted with 2 elements in flight, len=6 -> d_valid_o=0 the next cycle, FSM in IDLE, no done_o. A following start with len=2 completes correctly.
